// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and parameter limits for the hazard controller
package hazard_pkg;

  localparam int REG_AW_DEFAULT = 5;

  localparam int LOAD_LAT_MIN     = 1;
  localparam int LOAD_LAT_MAX     = 7;
  localparam int FLUSH_CYCLES_MIN = 1;
  localparam int FLUSH_CYCLES_MAX = 4;

  // Widths sized for the maximum legal LOAD_LAT-1 and FLUSH_CYCLES-1.
  localparam int BUSY_W      = 3;
  localparam int FLUSH_CNT_W = 2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } hazardState_e;

  function automatic int clampInt(input int value, input int lo, input int hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - per-register load countdown and per-operand hit lookup
module load_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = REG_AW_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      advance,
  input  logic                      ex_valid,
  input  logic                      ex_mem_read,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  output logic [NUM_SRC-1:0]        hit
);

  localparam int NUM_REGS = 1 << REG_AW;
  localparam logic [BUSY_W-1:0] BusyLoad = BUSY_W'(LOAD_LAT - 1);

  logic [BUSY_W-1:0] busy [NUM_REGS];
  logic              liveLoad;
  logic              loadIssue;

  assign liveLoad  = ex_valid & ex_mem_read;
  assign loadIssue = liveLoad & (ex_rd != '0);

  // A load in ID/EX covers its own cycle combinationally; the counter covers
  // the remaining LOAD_LAT-1 cycles, so LOAD_LAT=1 never leaves a count behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        busy[i] <= '0;
      end
    end else if (advance) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (loadIssue && (ex_rd == REG_AW'(i))) begin
          busy[i] <= BusyLoad;
        end else if (busy[i] != '0) begin
          busy[i] <= busy[i] - BUSY_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : gOperand
    logic [REG_AW-1:0] rs;
    assign rs     = id_rs[k*REG_AW +: REG_AW];
    assign hit[k] = id_rs_used[k] && (rs != '0) &&
                    ((busy[rs] != '0) || (liveLoad && (ex_rd == rs)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, branch flush and freeze control
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_SRC      = 2,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_AW       = REG_AW_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic                      ex_mem_read,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      branch_taken,
  input  logic                      mem_wait,
  output logic                      stall,
  output logic                      pc_write,
  output logic                      if_id_write,
  output logic                      id_ex_bubble,
  output logic                      flush,
  output logic [NUM_SRC-1:0]        hazard_src,
  output logic [15:0]               stall_count
);

  localparam int LoadLatC    = clampInt(LOAD_LAT, LOAD_LAT_MIN, LOAD_LAT_MAX);
  localparam int FlushCycC   = clampInt(FLUSH_CYCLES, FLUSH_CYCLES_MIN, FLUSH_CYCLES_MAX);
  localparam logic [FLUSH_CNT_W-1:0] FlushLoad = FLUSH_CNT_W'(FlushCycC - 1);

  hazardState_e             state;
  hazardState_e             nextState;
  logic [FLUSH_CNT_W-1:0]   flushCnt;
  logic [FLUSH_CNT_W-1:0]   nextFlushCnt;
  logic [NUM_SRC-1:0]       hit;

  load_scoreboard #(
    .NUM_SRC  (NUM_SRC),
    .LOAD_LAT (LoadLatC),
    .REG_AW   (REG_AW)
  ) uScoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (!mem_wait),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs       (id_rs),
    .id_rs_used  (id_rs_used),
    .hit         (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      flushCnt <= '0;
    end else begin
      state    <= nextState;
      flushCnt <= nextFlushCnt;
    end
  end

  // Priority: reset, freeze, flush (FLUSH state or newly accepted branch), stall.
  always_comb begin
    nextState    = state;
    nextFlushCnt = flushCnt;
    stall        = 1'b0;
    id_ex_bubble = 1'b0;
    flush        = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    hazard_src   = rst_n ? hit : '0;

    if (!rst_n) begin
      nextState    = ST_RUN;
      nextFlushCnt = '0;
    end else if (mem_wait) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (state == ST_FLUSH) begin
      // Any branch_taken here belongs to a squashed instruction.
      flush = 1'b1;
      if (flushCnt <= FLUSH_CNT_W'(1)) begin
        nextState    = ST_RUN;
        nextFlushCnt = '0;
      end else begin
        nextFlushCnt = flushCnt - FLUSH_CNT_W'(1);
      end
    end else if (branch_taken) begin
      flush = 1'b1;
      if (FlushLoad != '0) begin
        nextState    = ST_FLUSH;
        nextFlushCnt = FlushLoad;
      end
    end else if (|hit) begin
      stall        = 1'b1;
      id_ex_bubble = 1'b1;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule
